ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the send-side companion of the existing ps2 receiver, and both run on the board clock CLK.
- Sends one command byte per request to the keyboard/mouse using the open-drain inhibit/request-to-send protocol. Example: 0xED set-LEDs, then the LED mask.
- Reports whether the device acknowledged. Asserts tx_busy_o so the top level can gate the ps2 receiver during a transmission.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_host_tx.sv | 176 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size and 50 MHz timing defaults.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT1,
    SEND,
    ACK,
    BUSWAIT,
    ERR
  } ps2_tx_state_e;

  localparam int PS2_FRAME_BITS = 10;

  localparam int PS2_INHIBIT_CYC   = 5000;    // 100 us clock inhibit
  localparam int PS2_START_CYC     = 50;      // 1 us with both lines low
  localparam int PS2_TMO_START_CYC = 750000;  // 15 ms for the device to start clocking
  localparam int PS2_TMO_FRAME_CYC = 100000;  // 2 ms for the rest of the frame
  localparam int PS2_FILTER_LEN    = 8;

  // Host-to-device frame, LSB shifted first: data, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 pad: 2-FF synchronizer, glitch filter
// requiring FILTER_LEN consecutive equal samples, and a one-cycle falling-edge strobe.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run;
  logic          level_d1;

  // Synchronize, then only follow the pad once it has disagreed long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      run      <= '0;
      level    <= 1'b1;
      level_d1 <= 1'b1;
    end else begin
      sync     <= {sync[0], line};
      level_d1 <= level;
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        run   <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

  assign fall = level_d1 & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on
// device clock falls, ACK sampling and start/frame timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC   = PS2_INHIBIT_CYC,
  parameter int START_CYC     = PS2_START_CYC,
  parameter int TMO_START_CYC = PS2_TMO_START_CYC,
  parameter int TMO_FRAME_CYC = PS2_TMO_FRAME_CYC,
  parameter int FILTER_LEN    = PS2_FILTER_LEN
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_req_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_ack_o,
  output logic       tx_err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int TMO_MAX_A = (TMO_START_CYC > TMO_FRAME_CYC) ? TMO_START_CYC : TMO_FRAME_CYC;
  localparam int TMO_MAX   = (TMO_MAX_A > INHIBIT_CYC) ? TMO_MAX_A : INHIBIT_CYC;
  localparam int TW        = $clog2(TMO_MAX + 1);

  ps2_tx_state_e             state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_cnt;
  logic [TW-1:0]             tmr;

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk_i),
    .rst   (rst_i),
    .line  (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk_i),
    .rst   (rst_i),
    .line  (ps2_data_i),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  function automatic logic [TW-1:0] tmr_inc(input logic [TW-1:0] t);
    return (t == '1) ? t : t + TW'(1);
  endfunction

  // Frame register loads only on acceptance; it carries no control meaning.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && tx_req_i) begin
      frame <= ps2_frame(tx_data_i);
    end
  end

  // Transmit sequencer with registered pad enables and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
      tx_busy_o     <= 1'b0;
      tx_done_o     <= 1'b0;
      tx_ack_o      <= 1'b0;
      tx_err_o      <= 1'b0;
      tmr           <= '0;
      bit_cnt       <= '0;
    end else begin
      tx_done_o <= 1'b0;
      tx_err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          ps2_clk_oe_o  <= 1'b0;
          ps2_data_oe_o <= 1'b0;
          if (tx_req_i) begin
            tx_ack_o     <= 1'b0;
            tx_busy_o    <= 1'b1;
            ps2_clk_oe_o <= 1'b1;
            tmr          <= '0;
            state        <= INHIBIT;
          end
        end
        // Device clock falls here are contention; the host keeps holding the clock.
        INHIBIT: begin
          if (tmr >= TW'(INHIBIT_CYC - 1)) begin
            tmr           <= '0;
            ps2_data_oe_o <= 1'b1;
            state         <= REQ;
          end else begin
            tmr <= tmr_inc(tmr);
          end
        end
        REQ: begin
          if (tmr >= TW'(START_CYC - 1)) begin
            tmr          <= '0;
            ps2_clk_oe_o <= 1'b0;
            state        <= WAIT1;
          end else begin
            tmr <= tmr_inc(tmr);
          end
        end
        WAIT1: begin
          if (clk_fall) begin
            ps2_data_oe_o <= ~frame[0];
            bit_cnt       <= 4'd1;
            tmr           <= '0;
            state         <= SEND;
          end else if (tmr >= TW'(TMO_START_CYC - 1)) begin
            ps2_data_oe_o <= 1'b0;
            state         <= ERR;
          end else begin
            tmr <= tmr_inc(tmr);
          end
        end
        SEND: begin
          tmr <= tmr_inc(tmr);
          if (tmr >= TW'(TMO_FRAME_CYC - 1)) begin
            ps2_data_oe_o <= 1'b0;
            state         <= ERR;
          end else if (clk_fall) begin
            ps2_data_oe_o <= ~frame[bit_cnt];
            bit_cnt       <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          tmr <= tmr_inc(tmr);
          if (tmr >= TW'(TMO_FRAME_CYC - 1)) begin
            state <= ERR;
          end else if (clk_fall) begin
            tx_ack_o <= ~data_level;
            tx_err_o <= data_level;
            state    <= BUSWAIT;
          end
        end
        BUSWAIT: begin
          tmr <= tmr_inc(tmr);
          if (tmr >= TW'(TMO_FRAME_CYC - 1)) begin
            state <= ERR;
          end else if (clk_level && data_level) begin
            tx_done_o <= 1'b1;
            tx_busy_o <= 1'b0;
            state     <= IDLE;
          end
        end
        ERR: begin
          ps2_clk_oe_o  <= 1'b0;
          ps2_data_oe_o <= 1'b0;
          tx_err_o      <= 1'b1;
          tx_done_o     <= 1'b1;
          tx_ack_o      <= 1'b0;
          tx_busy_o     <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          ps2_clk_oe_o  <= 1'b0;
          ps2_data_oe_o <= 1'b0;
          tx_busy_o     <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, device BFM and a scoreboard of
// expected bus bits and transfer outcomes.
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int STC = 10;
  localparam int TS  = 3000;
  localparam int TF  = 6000;
  localparam int FL  = 8;
  localparam int H   = 40;   // device half clock period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       busy, done, ack, err, clk_oe, data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;

  wire ps2_clk  = ~(clk_oe | dev_clk_low | glitch_low);
  wire ps2_data = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC   (INH),
    .START_CYC     (STC),
    .TMO_START_CYC (TS),
    .TMO_FRAME_CYC (TF),
    .FILTER_LEN    (FL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_data_i     (tx_data),
    .tx_req_i      (tx_req),
    .tx_busy_o     (busy),
    .tx_done_o     (done),
    .tx_ack_o      (ack),
    .tx_err_o      (err),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic exp_bits[$];
  logic exp_ack_q[$];

  int   done_cnt = 0, err_cnt = 0;
  logic ack_at_done = 1'b0;
  int   oe_run = 0, oe_run_max = 0;
  int   err_cyc = 0, rel_cyc = 0, first_edge_cyc = 0;
  logic clk_oe_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) begin
      ack_at_done = ack;
      done_cnt++;
    end
    if (err) begin
      err_cyc = cyc;
      err_cnt++;
    end
    if (clk_oe) oe_run++;
    else begin
      if (oe_run > oe_run_max) oe_run_max = oe_run;
      oe_run = 0;
    end
    if (clk_oe_prev && !clk_oe) rel_cyc = cyc;
    clk_oe_prev = clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic exp_ack);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
    exp_ack_q.push_back(exp_ack);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    if (exp_bits.size() == 0) chk({tag, "_sb_empty"}, exp_bits.size(), 1);
    else begin
      e = exp_bits.pop_front();
      chk(tag, ps2_data, e);
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks nedges falls, samples on rises.
  task automatic dev_frame(input int nedges, input bit do_ack, input bit glitch);
    int w = 0;
    int g;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && w < 1000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 1000) begin
      chk("rts_wait_to", w, 0);
      return;
    end
    repeat (20) @(posedge clk);
    sample_bit("start");
    for (int i = 1; i <= nedges && i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == 1) first_edge_cyc = cyc;
      repeat (H) @(posedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) sample_bit($sformatf("bit%0d", i));
      if (i == 10 && do_ack) begin
        repeat (15) @(posedge clk);
        dev_data_low = 1'b1;
        repeat (H - 15) @(posedge clk);
      end else if (glitch && i >= 2 && i <= 9) begin
        g = 1 + (i % 3);
        repeat (10) @(posedge clk);
        glitch_low = 1'b1;
        repeat (g) @(posedge clk);
        glitch_low = 1'b0;
        repeat (H - 10 - g) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt != base), 1);
  endtask

  task automatic check_outcome(input string tag);
    logic e;
    if (exp_ack_q.size() == 0) chk({tag, "_ack_sb_empty"}, exp_ack_q.size(), 1);
    else begin
      e = exp_ack_q.pop_front();
      chk({tag, "_ack"}, ack_at_done, e);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit do_ack, input bit glitch);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(d, do_ack);
    fork
      send_req(d);
      dev_frame(11, do_ack, glitch);
    join
    wait_done(tag, d0, 500);
    check_outcome(tag);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_err_cnt"}, err_cnt - e0, do_ack ? 0 : 1);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, n, delta;
    bit busy_seen;

    // Reset state.
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xED with ACK.
    run_frame("t1", 8'hED, 1'b1, 1'b0);
    chk("t1_inhibit_len", (oe_run_max >= INH), 1);

    // 2: 0x07 without ACK.
    run_frame("t2", 8'h07, 1'b0, 1'b0);

    // 3: device never clocks.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h55);
    n = 0;
    while (err_cnt == e0 && n < INH + STC + TS + 500) begin
      @(negedge clk);
      n++;
    end
    chk("t3_err_seen", err_cnt - e0, 1);
    delta = err_cyc - rel_cyc;
    chk("t3_tmo_window", (delta >= TS && delta <= TS + 1), 1);
    chk("t3_clk_oe", clk_oe, 0);
    chk("t3_data_oe", data_oe, 0);
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_ack", ack_at_done, 0);
    @(negedge clk);
    chk("t3_idle", busy, 0);
    repeat (20) @(negedge clk);

    // 4: device stops after 5 edges.
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(8'hC3, 1'b0);
    fork
      send_req(8'hC3);
      dev_frame(5, 1'b0, 1'b0);
    join
    n = 0;
    while (err_cnt == e0 && n < TF + 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_err_seen", err_cnt - e0, 1);
    delta = err_cyc - first_edge_cyc;
    chk("t4_tmo_window", (delta >= TF && delta <= TF + FL + 8), 1);
    chk("t4_clk_oe", clk_oe, 0);
    chk("t4_data_oe", data_oe, 0);
    chk("t4_done", done_cnt - d0, 1);
    check_outcome("t4");
    exp_bits.delete();
    repeat (20) @(negedge clk);

    // 5: short glitches on the clock pad while bits are shifting.
    run_frame("t5", 8'hA5, 1'b1, 1'b1);

    // 6: reset mid-frame, then a request while busy is dropped.
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(8'h3C, 1'b0);
    fork
      send_req(8'h3C);
      dev_frame(4, 1'b0, 1'b0);
    join
    @(negedge clk);
    chk("t6_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_clk_oe", clk_oe, 0);
    chk("t6_rst_data_oe", data_oe, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("t6_rst_no_done", done_cnt - d0, 0);
    chk("t6_rst_no_err", err_cnt - e0, 0);
    exp_bits.delete();
    void'(exp_ack_q.pop_back());

    d0 = done_cnt;
    push_frame(8'h96, 1'b1);
    fork
      begin
        send_req(8'h96);
        repeat (50) @(negedge clk);
        tx_data = 8'h11;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
      end
      dev_frame(11, 1'b1, 1'b0);
    join
    wait_done("t6a", d0, 500);
    check_outcome("t6a");
    chk("t6a_done_cnt", done_cnt - d0, 1);
    busy_seen = 1'b0;
    repeat (INH + 50) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("t6_not_queued", busy_seen, 0);

    run_frame("t6b", 8'h5A, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
